fml_dma_rd: RTL



---
 rtl/fml_dma_rd_pkg.sv | 17 +
 rtl/fml_dma_rd_fifo.sv | 65 ++++++
 rtl/fml_dma_rd.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/fml_dma_rd_pkg.sv
// Shared definitions for the FML read initiator.
//   state_e     : controller states (idle, request, data, wait-for-room)
//   BURST_LEN   : data beats per FML burst
//   BURST_BYTES : bytes covered by one burst
package fml_dma_rd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StData,
    StWait
  } state_e;

  localparam int unsigned BURST_LEN   = 4;
  localparam int unsigned BURST_BYTES = 16;

endpackage

// File: rtl/fml_dma_rd_fifo.sv
// Synchronous word FIFO with registered storage; a word pushed in cycle C is visible at
// dout with valid=1 in cycle C+1 (no fall-through).
// Ports:
//   sys_clk, sys_rst : clock, synchronous active-high reset (empties the FIFO)
//   push, din        : write strobe and data
//   pop              : remove head word (ignored when empty)
//   dout, valid      : head word (0 when empty) and non-empty flag
//   level            : number of stored words
module fml_dma_rd_fifo #(
  parameter int unsigned fifo_depth = 16
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          push,
  input  logic [31:0]                   din,
  input  logic                          pop,
  output logic [31:0]                   dout,
  output logic                          valid,
  output logic [$clog2(fifo_depth):0]   level
);

  localparam int unsigned AddrW  = $clog2(fifo_depth);
  localparam int unsigned LevelW = AddrW + 1;

  logic [31:0]       mem_q [fifo_depth];
  logic [AddrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LevelW-1:0] level_q, level_d;
  logic              do_push, do_pop;

  assign do_pop  = pop & (level_q != '0);
  assign do_push = push & (level_q != LevelW'(fifo_depth));

  always_ff @(posedge sys_clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + LevelW'(1);
    end else if (do_pop && !do_push) begin
      level_d = level_q - LevelW'(1);
    end
  end

  // Pointers wrap naturally because fifo_depth is a power of two.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      level_q <= level_d;
    end
  end

  assign valid = (level_q != '0);
  assign dout  = valid ? mem_q[rd_ptr_q] : 32'h0;
  assign level = level_q;

endmodule

// File: rtl/fml_dma_rd.sv
// FML read initiator: reads nbursts consecutive 16-byte bursts starting at base_adr and
// streams the 32-bit words out over a valid/ready interface through an internal FIFO.
// A burst is requested only when the FIFO can absorb all of its beats.
// Optional feature: define FML_DMA_RD_LOOP_EN to restart the transfer from the latched base
// after the last burst, pulsing done each pass, until abort.
// Ports:
//   sys_clk, sys_rst        : clock, synchronous active-high reset
//   start, abort            : start pulse (ignored while busy), abort level (burst boundary)
//   base_adr, nbursts       : start byte address (bits [3:0] ignored), burst count
//   busy, done              : transfer active, one-cycle completion/abort pulse
//   fml_adr/stb/we/sel/ack  : FML request side
//   fml_di                  : FML read data
//   st_data/st_valid/st_ready : output stream
module fml_dma_rd
  import fml_dma_rd_pkg::*;
#(
  parameter int unsigned sdram_depth = 26,
  parameter int unsigned nburst_w    = 20,
  parameter int unsigned fifo_depth  = 16
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [sdram_depth-1:0] base_adr,
  input  logic [nburst_w-1:0]    nbursts,
  output logic                   busy,
  output logic                   done,
  output logic [sdram_depth-1:0] fml_adr,
  output logic                   fml_stb,
  output logic                   fml_we,
  output logic [3:0]             fml_sel,
  input  logic                   fml_ack,
  input  logic [31:0]            fml_di,
  output logic [31:0]            st_data,
  output logic                   st_valid,
  input  logic                   st_ready
);

  state_e                   state_q, state_d;
  logic [sdram_depth-1:0]   cur_adr_q, cur_adr_d;
  logic [nburst_w-1:0]      remaining_q, remaining_d;
  logic [1:0]               beat_q, beat_d;
  logic                     done_q, done_d;
  logic                     push;
  logic                     room;
  logic [$clog2(fifo_depth):0] fifo_level;
  logic [sdram_depth-1:0]   aligned_base;
  logic                     unused_base_lsbs;

  assign aligned_base     = {base_adr[sdram_depth-1:4], 4'h0};
  assign unused_base_lsbs = ^base_adr[3:0];

  // Room for a whole burst must exist before the request goes out; this is what makes
  // FIFO overflow impossible.
  assign room = (32'(fifo_level) <= fifo_depth - BURST_LEN);

`ifdef FML_DMA_RD_LOOP_EN
  logic [sdram_depth-1:0] base_q, base_d;
  logic [nburst_w-1:0]    nb_q, nb_d;
`endif

  always_comb begin
    state_d     = state_q;
    cur_adr_d   = cur_adr_q;
    remaining_d = remaining_q;
    beat_d      = beat_q;
    done_d      = 1'b0;
    push        = 1'b0;
`ifdef FML_DMA_RD_LOOP_EN
    base_d      = base_q;
    nb_d        = nb_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (nbursts == '0) begin
            done_d = 1'b1;
          end else begin
            cur_adr_d   = aligned_base;
            remaining_d = nbursts;
`ifdef FML_DMA_RD_LOOP_EN
            base_d      = aligned_base;
            nb_d        = nbursts;
`endif
            state_d     = StWait;
          end
        end
      end
      StWait: begin
        if (abort) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (room) begin
          state_d = StReq;
        end
      end
      StReq: begin
        // Strobe is held until ack regardless of abort.
        if (fml_ack) begin
          beat_d  = 2'd0;
          state_d = StData;
        end
      end
      StData: begin
        push   = 1'b1;
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'(BURST_LEN - 1)) begin
          cur_adr_d   = cur_adr_q + sdram_depth'(BURST_BYTES);
          remaining_d = remaining_q - nburst_w'(1);
          if (remaining_q == nburst_w'(1)) begin
            done_d = 1'b1;
`ifdef FML_DMA_RD_LOOP_EN
            cur_adr_d   = base_q;
            remaining_d = nb_q;
            state_d     = StWait;
`else
            state_d     = StIdle;
`endif
          end else begin
            state_d = StWait;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      cur_adr_q   <= '0;
      remaining_q <= '0;
      beat_q      <= 2'd0;
      done_q      <= 1'b0;
`ifdef FML_DMA_RD_LOOP_EN
      base_q      <= '0;
      nb_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cur_adr_q   <= cur_adr_d;
      remaining_q <= remaining_d;
      beat_q      <= beat_d;
      done_q      <= done_d;
`ifdef FML_DMA_RD_LOOP_EN
      base_q      <= base_d;
      nb_q        <= nb_d;
`endif
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign fml_stb = (state_q == StReq);
  assign fml_adr = cur_adr_q;
  assign fml_we  = 1'b0;
  assign fml_sel = 4'hf;

  fml_dma_rd_fifo #(
    .fifo_depth (fifo_depth)
  ) u_fifo (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .push    (push),
    .din     (fml_di),
    .pop     (st_ready),
    .dout    (st_data),
    .valid   (st_valid),
    .level   (fifo_level)
  );

endmodule
